// File: rtl/bit_select_sequential_pkg.sv
// Shared types and helpers for the sequential bit-select unit (select half of rank/select).
// The operand is scanned one byte per cycle; popcounts decide which byte holds the wanted bit.
package bit_select_pkg;

   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int POSITION_WIDTH     = $clog2(DATA_WIDTH_DEFAULT);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      SELECT,
      DONE
   } state_t;

   // Number of set bits in one byte, 0..8, so four bits are needed.
   function automatic logic [3:0] byte_popcount(input logic [7:0] value);
      logic [3:0] count;
      count = '0;
      for (int i = 0; i < 8; i++) begin
         count = count + {3'b000, value[i]};
      end
      return count;
   endfunction

endpackage

// File: rtl/bit_select_sequential_if.sv
// Request/response bundle of the bit-select unit: the word and rank go in, and the
// position/found result comes back with a one-cycle valid pulse.
interface bit_select_sequential_if
   import bit_select_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

   localparam int BYTES_NUMBER = DATA_WIDTH / 8;
   localparam int POS_W        = $clog2(DATA_WIDTH);

   logic [BYTES_NUMBER-1:0][7:0] operand_i;
   logic [POS_W-1:0]             rank_i;
   logic                         valid_i;
   logic                         ready_o;
   logic [POS_W-1:0]             position_o;
   logic                         found_o;
   logic                         valid_o;

   modport master (
      output operand_i,
      output rank_i,
      output valid_i,
      input  ready_o,
      input  position_o,
      input  found_o,
      input  valid_o
   );

   modport slave (
      input  operand_i,
      input  rank_i,
      input  valid_i,
      output ready_o,
      output position_o,
      output found_o,
      output valid_o
   );

endinterface

// File: rtl/bit_select_sequential_byte_bit_select.sv
// Combinational helper that returns the index of the rank-th set bit inside one byte.
// The caller guarantees that the byte holds more than rank set bits.
module byte_bit_select (
   input  logic [7:0] byte_value,
   input  logic [2:0] rank,
   output logic [2:0] bit_index
);

   logic [3:0] running_count;
   logic       located;

   // LSB-first walk: the first set bit reached when the running count equals rank wins.
   always_comb begin
      bit_index     = '0;
      running_count = '0;
      located       = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (byte_value[i]) begin
            if (!located && (running_count == {1'b0, rank})) begin
               bit_index = 3'(i);
               located   = 1'b1;
            end
            running_count = running_count + 4'd1;
         end
      end
   end

endmodule

// File: rtl/bit_select_sequential.sv
// Sequential select: finds the bit position of the k-th set bit of the operand by
// skipping whole bytes using their popcounts, then resolving the bit inside the hit byte.
module bit_select_sequential
   import bit_select_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   bit_select_sequential_if.slave  bus
);

   localparam int BYTES_NUMBER = DATA_WIDTH / 8;
   localparam int POS_W        = $clog2(DATA_WIDTH);
   localparam int BYTE_IDX_W   = (BYTES_NUMBER > 1) ? $clog2(BYTES_NUMBER) : 1;
   localparam int CMP_W        = POS_W + 1;

   state_t                       state_q;
   state_t                       state_d;
   logic [BYTES_NUMBER-1:0][7:0] operand_q;
   logic [POS_W-1:0]             remaining_q;
   logic [BYTE_IDX_W-1:0]        byte_idx_q;
   logic [POS_W-1:0]             position_q;
   logic                         found_q;
   logic                         valid_q;

   logic [7:0]                   cur_byte;
   logic [3:0]                   cur_count;
   logic                         hit;
   logic                         last_byte;
   logic [2:0]                   bit_index;
   logic [POS_W-1:0]             sel_position;

   // The byte under inspection stays selected through SELECT because byte_idx is held on a hit.
   assign cur_byte     = operand_q[byte_idx_q];
   assign cur_count    = byte_popcount(cur_byte);
   assign hit          = CMP_W'(remaining_q) < CMP_W'(cur_count);
   assign last_byte    = (byte_idx_q == BYTE_IDX_W'(BYTES_NUMBER - 1));
   assign sel_position = POS_W'({byte_idx_q, bit_index});

   byte_bit_select u_byte_bit_select (
      .byte_value (cur_byte),
      .rank       (remaining_q[2:0]),
      .bit_index  (bit_index)
   );

   // State register; reset drops any request that is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: one byte per SCAN cycle, a single SELECT cycle, a single DONE cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (hit) begin
               state_d = SELECT;
            end else if (last_byte) begin
               state_d = DONE;
            end
         end
         SELECT:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: remaining counts down by each skipped byte's popcount, so it never underflows.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         operand_q   <= '0;
         remaining_q <= '0;
         byte_idx_q  <= '0;
         position_q  <= '0;
         found_q     <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         valid_q <= (state_d == DONE);
         case (state_q)
            IDLE: begin
               if (bus.valid_i) begin
                  operand_q   <= bus.operand_i;
                  remaining_q <= bus.rank_i;
                  byte_idx_q  <= '0;
               end
            end
            SCAN: begin
               if (!hit) begin
                  if (last_byte) begin
                     found_q    <= 1'b0;
                     position_q <= '0;
                  end else begin
                     remaining_q <= remaining_q - POS_W'(cur_count);
                     byte_idx_q  <= byte_idx_q + BYTE_IDX_W'(1);
                  end
               end
            end
            SELECT: begin
               position_q <= sel_position;
               found_q    <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ready_o    = (state_q == IDLE);
   assign bus.position_o = position_q;
   assign bus.found_o    = found_q;
   assign bus.valid_o    = valid_q;

endmodule
